adat_frame_lock_supervisor: RTL and testbench



---
 rtl/adat_pkg.sv | 18 +
 rtl/adat_slot_counter.sv | 36 +++
 rtl/adat_frame_lock_supervisor.sv | 184 ++++++++++++++++++
 tb/tb_adat_frame_lock_supervisor.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adat_pkg.sv
// Shared types and constants for the ADAT receive path (decoder, lock supervisor, deframer).
package adat_pkg;

    typedef enum logic [1:0] {
        StHunt,
        StAcquire,
        StLocked,
        StHoldover
    } lock_state_e;

    localparam int ADAT_FRAME_BITS = 256;
    localparam int ADAT_SYNC_ZEROS = 10;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/adat_slot_counter.sv
// Slot position counter: advances once per decoded bit, can be cleared or reloaded to 1,
// and sticks at MAX instead of wrapping.
module adat_slot_counter #(
    parameter int CNT_W = 9,
    parameter int MAX   = 272
) (
    input  logic             clk_x4_i,
    input  logic             rst_ni,
    input  logic             en,
    input  logic             clr,
    input  logic             load_one,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk_x4_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_reg <= '0;
        end else if (en) begin
            if (clr) begin
                cnt_reg <= '0;
            end else if (load_one) begin
                cnt_reg <= CNT_ONE;
            end else if (cnt_reg != CNT_MAX) begin
                cnt_reg <= cnt_reg + CNT_ONE;
            end
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/adat_frame_lock_supervisor.sv
// Frame-lock supervisor: times ADAT sync edges on decoded-bit slots, declares and drops
// lock with hysteresis, and flywheels frame boundaries across isolated missing syncs.
module adat_frame_lock_supervisor
    import adat_pkg::*;
#(
    parameter int FRAME_BITS    = ADAT_FRAME_BITS,
    parameter int LOCK_FRAMES   = 4,
    parameter int UNLOCK_FRAMES = 3,
    parameter int SLACK_BITS    = 16,
    parameter int CNT_W         = $clog2(FRAME_BITS + SLACK_BITS + 1)
) (
    input  logic             clk_x4_i,
    input  logic             rst_ni,
    input  logic             dec_tick_ni,
    input  logic             dec_data_i,
    input  logic             dec_valid_i,
    input  logic             dec_sync_i,
    output logic             locked_o,
    output logic             frame_start_o,
    output logic             bit_o,
    output logic [CNT_W-1:0] bit_idx_o,
    output logic             frame_err_o,
    output logic [7:0]       lock_loss_cnt_o
);

    localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);
    localparam int BAD_W  = $clog2(UNLOCK_FRAMES + 1);

    localparam logic [CNT_W-1:0]  CNT_FRAME = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(FRAME_BITS + SLACK_BITS);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_FRAMES - 1);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(UNLOCK_FRAMES - 1);

    lock_state_e       state_reg;
    logic [GOOD_W-1:0] good_reg;
    logic [BAD_W-1:0]  bad_reg;
    logic              sync_prev_reg;
    logic              locked_reg;
    logic              frame_start_reg;
    logic              frame_err_reg;
    logic              bit_reg;
    logic [7:0]        lock_loss_reg;
    logic [CNT_W-1:0]  cnt;

    logic slot;
    logic sync_edge;
    logic at_frame;
    logic at_limit;
    logic in_lock;
    logic good_boundary;
    logic miss;
    logic unlock;
    logic cnt_clr;
    logic cnt_load;

    assign slot          = ~dec_tick_ni;
    assign sync_edge     = dec_sync_i & ~sync_prev_reg;
    assign at_frame      = (cnt == CNT_FRAME);
    assign at_limit      = (cnt == CNT_LIMIT);
    assign in_lock       = (state_reg == StLocked) || (state_reg == StHoldover);
    assign good_boundary = sync_edge & at_frame;
    // A locked frame is bad when the edge is off-grid or the grid expires without an edge.
    assign miss          = in_lock & (sync_edge ^ at_frame);
    assign unlock        = miss & (bad_reg == BAD_LAST);

    always_comb begin
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        if (!dec_valid_i) begin
            cnt_clr = 1'b1;
        end else begin
            case (state_reg)
                StHunt: begin
                    cnt_load = sync_edge;
                    cnt_clr  = ~sync_edge;
                end
                StAcquire: begin
                    cnt_load = sync_edge;
                    cnt_clr  = ~sync_edge & at_limit;
                end
                default: begin
                    cnt_load = good_boundary | (miss & ~unlock);
                    cnt_clr  = unlock;
                end
            endcase
        end
    end

    adat_slot_counter #(
        .CNT_W (CNT_W),
        .MAX   (FRAME_BITS + SLACK_BITS)
    ) u_slot_counter (
        .clk_x4_i (clk_x4_i),
        .rst_ni   (rst_ni),
        .en       (slot),
        .clr      (cnt_clr),
        .load_one (cnt_load),
        .cnt      (cnt)
    );

    always_ff @(posedge clk_x4_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg       <= StHunt;
            good_reg        <= '0;
            bad_reg         <= '0;
            sync_prev_reg   <= 1'b0;
            locked_reg      <= 1'b0;
            frame_start_reg <= 1'b0;
            frame_err_reg   <= 1'b0;
            bit_reg         <= 1'b0;
            lock_loss_reg   <= '0;
        end else begin
            frame_start_reg <= 1'b0;
            frame_err_reg   <= 1'b0;
            if (slot) begin
                sync_prev_reg <= dec_sync_i;
                bit_reg       <= dec_data_i;
                if (!dec_valid_i) begin
                    state_reg  <= StHunt;
                    good_reg   <= '0;
                    bad_reg    <= '0;
                    locked_reg <= 1'b0;
                    if (in_lock) begin
                        lock_loss_reg <= sat_inc8(lock_loss_reg);
                    end
                end else begin
                    case (state_reg)
                        StHunt: begin
                            if (sync_edge) begin
                                state_reg <= StAcquire;
                                good_reg  <= '0;
                            end
                        end
                        StAcquire: begin
                            if (good_boundary) begin
                                if (good_reg == GOOD_LAST) begin
                                    state_reg       <= StLocked;
                                    good_reg        <= '0;
                                    bad_reg         <= '0;
                                    locked_reg      <= 1'b1;
                                    frame_start_reg <= 1'b1;
                                end else begin
                                    good_reg <= good_reg + GOOD_W'(1);
                                end
                            end else if (sync_edge) begin
                                good_reg <= '0;
                            end else if (at_limit) begin
                                state_reg <= StHunt;
                                good_reg  <= '0;
                            end
                        end
                        default: begin
                            if (good_boundary) begin
                                state_reg       <= StLocked;
                                bad_reg         <= '0;
                                frame_start_reg <= 1'b1;
                            end else if (miss) begin
                                frame_err_reg <= 1'b1;
                                if (unlock) begin
                                    state_reg     <= StHunt;
                                    bad_reg       <= '0;
                                    locked_reg    <= 1'b0;
                                    lock_loss_reg <= sat_inc8(lock_loss_reg);
                                end else begin
                                    state_reg       <= StHoldover;
                                    bad_reg         <= bad_reg + BAD_W'(1);
                                    frame_start_reg <= 1'b1;
                                end
                            end
                        end
                    endcase
                end
            end
        end
    end

    assign locked_o        = locked_reg;
    assign frame_start_o   = frame_start_reg;
    assign frame_err_o     = frame_err_reg;
    assign bit_o           = bit_reg;
    assign bit_idx_o       = cnt;
    assign lock_loss_cnt_o = lock_loss_reg;

endmodule

// File: tb/tb_adat_frame_lock_supervisor.sv
// Directed bench for the frame-lock supervisor: timestamp-based reference model checked every
// cycle, plus literal expectations at the scenario milestones.
module tb_adat_frame_lock_supervisor;

    localparam int FRAME  = 256;
    localparam int LOCK   = 4;
    localparam int UNLOCK = 3;
    localparam int SLACK  = 16;
    localparam int LIMIT  = FRAME + SLACK;
    localparam int CNT_W  = $clog2(LIMIT + 1);

    localparam int M_HUNT = 0;
    localparam int M_ACQ  = 1;
    localparam int M_LOCK = 2;
    localparam int M_HOLD = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             tick_n;
    logic             data;
    logic             valid;
    logic             sync;
    logic             locked;
    logic             frame_start;
    logic             bit_out;
    logic [CNT_W-1:0] bit_idx;
    logic             frame_err;
    logic [7:0]       loss_cnt;

    int checks = 0;
    int errors = 0;
    int tail   = 0;
    bit compare_on = 1'b0;

    // reference model state: frame boundaries kept as absolute slot numbers
    int m_mode, m_slot, m_boundary, m_good, m_bad, m_losses;
    bit m_prev_sync;
    bit e_locked, e_start, e_bit, e_err;
    int e_idx;

    always #5 clk = ~clk;

    adat_frame_lock_supervisor #(
        .FRAME_BITS    (FRAME),
        .LOCK_FRAMES   (LOCK),
        .UNLOCK_FRAMES (UNLOCK),
        .SLACK_BITS    (SLACK),
        .CNT_W         (CNT_W)
    ) dut (
        .clk_x4_i        (clk),
        .rst_ni          (rst_n),
        .dec_tick_ni     (tick_n),
        .dec_data_i      (data),
        .dec_valid_i     (valid),
        .dec_sync_i      (sync),
        .locked_o        (locked),
        .frame_start_o   (frame_start),
        .bit_o           (bit_out),
        .bit_idx_o       (bit_idx),
        .frame_err_o     (frame_err),
        .lock_loss_cnt_o (loss_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_HUNT; m_slot = 0; m_boundary = 0;
        m_good = 0; m_bad = 0; m_losses = 0; m_prev_sync = 1'b0;
        e_locked = 1'b0; e_start = 1'b0; e_bit = 1'b0; e_err = 1'b0; e_idx = 0;
    endtask

    task automatic model_step();
        int gap;
        bit ev;
        e_start = 1'b0;
        e_err   = 1'b0;
        if (tick_n == 1'b0) begin
            m_slot++;
            e_bit = data;
            ev = sync && !m_prev_sync;
            m_prev_sync = sync;
            gap = m_slot - m_boundary;
            if (!valid) begin
                if (m_mode == M_LOCK || m_mode == M_HOLD)
                    m_losses = (m_losses < 255) ? m_losses + 1 : 255;
                m_mode = M_HUNT; m_good = 0; m_bad = 0;
            end else if (m_mode == M_HUNT) begin
                if (ev) begin m_mode = M_ACQ; m_boundary = m_slot; m_good = 0; end
            end else if (m_mode == M_ACQ) begin
                if (ev) begin
                    m_good = (gap == FRAME) ? m_good + 1 : 0;
                    m_boundary = m_slot;
                    if (m_good == LOCK) begin
                        m_mode = M_LOCK; m_good = 0; m_bad = 0; e_start = 1'b1;
                    end
                end else if (gap == LIMIT) begin
                    m_mode = M_HUNT;
                end
            end else if (ev || gap == FRAME) begin
                if (ev && gap == FRAME) begin
                    m_mode = M_LOCK; m_bad = 0; e_start = 1'b1; m_boundary = m_slot;
                end else begin
                    m_bad++;
                    e_err = 1'b1;
                    if (m_bad == UNLOCK) begin
                        m_mode = M_HUNT; m_bad = 0;
                        m_losses = (m_losses < 255) ? m_losses + 1 : 255;
                    end else begin
                        m_mode = M_HOLD; e_start = 1'b1; m_boundary = m_slot;
                    end
                end
            end
            e_locked = (m_mode == M_LOCK || m_mode == M_HOLD);
            if (m_mode == M_HUNT) e_idx = 0;
            else e_idx = (m_slot - m_boundary + 1 > LIMIT) ? LIMIT : m_slot - m_boundary + 1;
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else model_step();
        #1;
        if (compare_on) begin
            chk("locked", locked, e_locked);
            chk("frame_start", frame_start, e_start);
            chk("frame_err", frame_err, e_err);
            chk("bit", bit_out, e_bit);
            chk("bit_idx", bit_idx, e_idx);
            chk("lock_loss", loss_cnt, m_losses);
        end
    end

    // one slot = one tick cycle followed by one idle cycle
    task automatic slot_drive(input logic s, input logic v);
        @(negedge clk);
        tick_n = 1'b0; data = 1'($urandom_range(0, 1)); sync = s; valid = v;
        @(negedge clk);
        tick_n = 1'b1; data = 1'($urandom_range(0, 1));
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) begin
            slot_drive(tail > 0, 1'b1);
            if (tail > 0) tail--;
        end
    endtask

    // sync rises on the n-th slot from now and stays high for two more slots
    task automatic edge_after(input int n);
        quiet(n - 1);
        slot_drive(1'b1, 1'b1);
        tail = 2;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; tick_n = 1'b1; data = 1'b0; valid = 1'b1; sync = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_locked", locked, 0);
        chk("rst_idx", bit_idx, 0);
        chk("rst_loss", loss_cnt, 0);
        chk("rst_start", frame_start, 0);
        compare_on = 1'b1;
        rst_n = 1'b1;
        quiet(20);
        chk("hunt_idx", bit_idx, 0);

        // acquire: edges every 256 slots, lock on the fifth edge
        edge_after(10);
        chk("acq_idx", bit_idx, 1);
        chk("acq_locked", locked, 0);
        for (int i = 0; i < 3; i++) begin
            edge_after(FRAME);
            chk("acq_wait_locked", locked, 0);
        end
        edge_after(FRAME);
        chk("lock_locked", locked, 1);
        chk("lock_start", frame_start, 1);
        chk("lock_idx", bit_idx, 1);
        quiet(100);
        chk("mid_idx", bit_idx, 101);
        edge_after(156);
        chk("lock2_start", frame_start, 1);
        chk("lock2_err", frame_err, 0);

        // early edge realigns into holdover, next on-grid edge restores lock
        edge_after(250);
        chk("realign_err", frame_err, 1);
        chk("realign_start", frame_start, 1);
        chk("realign_idx", bit_idx, 1);
        chk("realign_locked", locked, 1);
        edge_after(FRAME);
        chk("relock_err", frame_err, 0);
        chk("relock_start", frame_start, 1);
        chk("relock_locked", locked, 1);
        edge_after(FRAME);

        // sync removed: two flywheeled boundaries, third miss drops lock
        quiet(FRAME);
        chk("fly1_start", frame_start, 1);
        chk("fly1_err", frame_err, 1);
        chk("fly1_idx", bit_idx, 1);
        quiet(FRAME);
        chk("fly2_start", frame_start, 1);
        chk("fly2_locked", locked, 1);
        quiet(FRAME);
        chk("fly3_start", frame_start, 0);
        chk("fly3_err", frame_err, 1);
        chk("fly3_locked", locked, 0);
        chk("fly3_idx", bit_idx, 0);
        chk("fly3_loss", loss_cnt, 1);

        // off-grid edge during acquire restarts the good-frame count
        edge_after(5);
        edge_after(FRAME);
        edge_after(FRAME);
        edge_after(260);
        chk("acq_bad_locked", locked, 0);
        for (int i = 0; i < 3; i++) edge_after(FRAME);
        chk("acq_three_locked", locked, 0);
        edge_after(FRAME);
        chk("acq_four_locked", locked, 1);

        // decoder invalid for one slot at bit 100
        quiet(98);
        chk("pre_drop_idx", bit_idx, 99);
        slot_drive(1'b0, 1'b0);
        chk("drop_locked", locked, 0);
        chk("drop_idx", bit_idx, 0);
        chk("drop_loss", loss_cnt, 2);
        quiet(10);
        chk("post_drop_idx", bit_idx, 0);

        // edges 300 apart never lock; acquire times out 272 slots after an edge
        edge_after(10);
        for (int i = 0; i < 3; i++) begin
            edge_after(300);
            chk("wide_locked", locked, 0);
            chk("wide_idx", bit_idx, 1);
        end
        quiet(LIMIT - 1);
        chk("slack_idx", bit_idx, LIMIT);
        quiet(1);
        chk("timeout_idx", bit_idx, 0);
        chk("timeout_locked", locked, 0);

        // asynchronous reset in the middle of a locked frame
        edge_after(10);
        for (int i = 0; i < LOCK; i++) edge_after(FRAME);
        quiet(50);
        chk("pre_rst_locked", locked, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_locked", locked, 0);
        chk("arst_idx", bit_idx, 0);
        chk("arst_loss", loss_cnt, 0);
        chk("arst_start", frame_start, 0);
        chk("arst_err", frame_err, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        quiet(20);
        chk("after_rst_idx", bit_idx, 0);
        edge_after(10);
        chk("after_rst_acq_idx", bit_idx, 1);
        quiet(5);

        compare_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
